tile_spawner: RTL and testbench
===============================

# tile_spawner

Post-move stage of the 2048 datapath that consumes the board produced by the move/merge stage. On each accepted move it counts the empty cells and, if the move changed the board, places a new 2 (or 4) tile in a pseudo-randomly chosen empty cell. It then evaluates the win and game-over conditions and presents the final board to the game controller with a one-cycle `done` pulse.

## Interface

**Parameters**
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `WIN_VALUE`, default 12'd2048: tile value that sets `win`.

**Ports**
- `clk` input, 1: system clock; all state changes on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: single-cycle request. `board_pre` and `board_in` are valid in this cycle (driven by the move/merge `done`).
- `board_pre` input, 12 x [3:0][3:0]: board before the move.
- `board_in` input, 12 x [3:0][3:0]: board after move/merge.
- `board_out` output, 12 x [3:0][3:0]: registered result board.
- `busy` output, 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` output, 1: one-cycle pulse; all result outputs update in this cycle.
- `spawned` output, 1: a tile was placed on the last operation.
- `win` output, 1: some cell of `board_out` is >= `WIN_VALUE`.
- `game_over` output, 1: `board_out` has no empty cell and no horizontally or vertically adjacent equal pair.

## Operation

**Capture**
- In IDLE, `start` latches `board_in` into the working board.
- `moved` is latched as (`board_in` != `board_pre`).
- `start` is ignored while `busy` is high.

**LFSR**
- 16-bit Galois LFSR, tap mask 16'hB400.
- Advances every cycle, including IDLE.
- Loads `SEED` on `rst`.

**FSM states: IDLE -> COUNT -> PICK -> PLACE -> CHECK -> DONE -> IDLE**
- COUNT: visits cells 0..15, one per cycle, in row-major order (index = row*4 + col). Accumulates `empty_cnt`, 5 bits, range 0..16.
- PICK (1 cycle):
  - If `moved` = 0 or `empty_cnt` = 0, skip PLACE and go to CHECK with `spawned` = 0.
  - Otherwise `target` = (`lfsr[7:0]` * `empty_cnt`) >> 8, giving a value in 0..`empty_cnt`-1. The product is 13 bits.
  - Latch the tile value: 12'd2, or 12'd4 if SPAWN_FOUR_EN is defined and `lfsr[11:8]` == 4'hF.
- PLACE: always 16 cycles, scanning cells 0..15. Writes the tile into the `target`-th empty cell (0-based count of empties in scan order) and sets `spawned` = 1. Exactly one cell is written.
- CHECK: 16 cycles, scanning cells 0..15 on the updated working board.
  - `any_empty` |= (cell == 0).
  - `any_pair` |= (cell == right neighbour, when col < 3) or (cell == down neighbour, when row < 3).
  - `any_win` |= (cell >= `WIN_VALUE`).
- DONE (1 cycle):
  - `board_out` <= working board.
  - `win` <= `any_win`.
  - `game_over` <= !`any_empty` && !`any_pair`.
  - `done` = 1.

**Arithmetic and output holding**
- Cell values are unsigned 12-bit. Comparisons are unsigned.
- No cell value other than the spawned tile is ever modified.
- `board_out`, `spawned`, `win` and `game_over` hold between `done` pulses.

## Timing

**Reset**
- Reset values: `board_out` all zero; `busy`, `done`, `spawned`, `win`, `game_over` = 0; FSM in IDLE; LFSR = `SEED`.
- `rst` during any state aborts the operation on the next edge. Reset has priority over `start` in the same cycle.

**Latency** (edges from the `start`-accepted edge to the edge that asserts `done`)
- With spawn: 16 (COUNT) + 1 (PICK) + 16 (PLACE) + 16 (CHECK) + 1 = 50.
- Without spawn (`moved` = 0 or board full): 34.

**Back-to-back and boundary behaviour**
- `done` and `busy` are both high in the DONE cycle.
- A `start` in the cycle after `done` is accepted (FSM back in IDLE).
- Full board with `moved` = 1 (possible only if merges produced no gap): no spawn, CHECK runs normally.
- `empty_cnt` = 16 gives `target` = `lfsr[7:0]` >> 4.

## Configuration

- `SPAWN_FOUR_EN`
  - Defined: spawned tile is 4 when `lfsr[11:8]` == 4'hF (1/16 probability), else 2.
  - Undefined: spawned tile is always 2; the comparison logic is not built.

## Test plan

- Reset, then hold `start` = 0 for 10 cycles -> all outputs zero, `busy` = 0.
- `board_pre` = `board_in`, with an identical half-filled board -> `done` at edge 34, `spawned` = 0, `board_out` == `board_in`.
- `board_pre` = zeros; `board_in` = all cells 2 except cell 7 = 0 and cells alternating 2/4 with no pairs -> `done` at edge 50; cell 7 = 2 (or 4 with the macro); `spawned` = 1; `game_over` = 1 (checkerboard with no pairs).
- `board_in` with cell 0 = 2048 and one empty cell, moved -> `win` = 1, `game_over` = 0.
- Full board containing adjacent 8,8 in row 2, `board_pre` differing -> `spawned` = 0, `game_over` = 0, latency 34.
- Assert `rst` at edge 20 of an operation -> next cycle `busy` = 0; `board_out` zero; no `done`; a following `start` completes in 50 edges.

Source files
------------

// File: rtl/tile_spawner.sv
// 2048 post-move stage: counts empty cells, spawns a tile into a pseudo-random empty cell,
// then scores win/game-over. Optional macro SPAWN_FOUR_EN allows a 4 tile at 1/16 probability.
module tile_spawner #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [11:0] WIN_VALUE = 12'd2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0][3:0][11:0]  board_pre,
    input  logic [3:0][3:0][11:0]  board_in,
    output logic [3:0][3:0][11:0]  board_out,
    output logic                   busy,
    output logic                   done,
    output logic                   spawned,
    output logic                   win,
    output logic                   game_over
);

    localparam int DATA_W = 12;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_PICK, S_PLACE, S_CHECK, S_DONE
    } state_t;

    state_t state, state_n;

    logic [15:0]                  lfsr;
    logic [3:0]                   idx;
    logic [3:0][3:0][DATA_W-1:0]  work;
    logic                         moved;
    logic [4:0]                   empty_cnt;
    logic [4:0]                   target;
    logic [4:0]                   seen;
    logic [DATA_W-1:0]            tile;
    logic                         spawn_flag;
    logic                         any_empty;
    logic                         any_pair;
    logic                         any_win;

    logic [1:0]        row, col;
    logic [DATA_W-1:0] cur, right_nb, down_nb;
    logic [12:0]       prod;
    logic              accept;

    assign row      = idx[3:2];
    assign col      = idx[1:0];
    assign cur      = work[row][col];
    assign right_nb = work[row][col + 2'd1];
    assign down_nb  = work[row + 2'd1][col];
    assign prod     = {5'd0, lfsr[7:0]} * {8'd0, empty_cnt};
    assign accept   = (state == S_IDLE) && start && !busy;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = S_COUNT;
            S_COUNT: if (idx == 4'd15) state_n = S_PICK;
            S_PICK:  state_n = (moved && (empty_cnt != 5'd0)) ? S_PLACE : S_CHECK;
            S_PLACE: if (idx == 4'd15) state_n = S_CHECK;
            S_CHECK: if (idx == 4'd15) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // LFSR free-runs in every state so the spawn position depends on start timing
    always_ff @(posedge clk) begin
        if (rst) lfsr <= SEED_EFF;
        else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept)    busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

    // Capture and scan stages share one cell index that wraps 15 -> 0 between scans
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (accept) begin
                    work       <= board_in;
                    moved      <= (board_in != board_pre);
                    idx        <= 4'd0;
                    empty_cnt  <= 5'd0;
                    spawn_flag <= 1'b0;
                    any_empty  <= 1'b0;
                    any_pair   <= 1'b0;
                    any_win    <= 1'b0;
                end
            end
            S_COUNT: begin
                if (cur == '0) empty_cnt <= empty_cnt + 5'd1;
                idx <= idx + 4'd1;
            end
            S_PICK: begin
                target <= prod[12:8];
                seen   <= 5'd0;
`ifdef SPAWN_FOUR_EN
                tile   <= (lfsr[11:8] == 4'hF) ? 12'd4 : 12'd2;
`else
                tile   <= 12'd2;
`endif
            end
            S_PLACE: begin
                if (cur == '0) begin
                    if (seen == target) begin
                        work[row][col] <= tile;
                        spawn_flag     <= 1'b1;
                    end
                    seen <= seen + 5'd1;
                end
                idx <= idx + 4'd1;
            end
            S_CHECK: begin
                if (cur == '0)                      any_empty <= 1'b1;
                if ((col != 2'd3) && (cur == right_nb)) any_pair <= 1'b1;
                if ((row != 2'd3) && (cur == down_nb))  any_pair <= 1'b1;
                if (cur >= WIN_VALUE)               any_win   <= 1'b1;
                idx <= idx + 4'd1;
            end
            default: ;
        endcase
    end

    // Result registers update only on the done pulse and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            board_out <= '0;
            spawned   <= 1'b0;
            win       <= 1'b0;
            game_over <= 1'b0;
        end else if (state == S_DONE) begin
            board_out <= work;
            spawned   <= spawn_flag;
            win       <= any_win;
            game_over <= !any_empty && !any_pair;
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Bench for tile_spawner: board-level model, per-cycle compare of all outputs, directed boards.
module tb_tile_spawner;

    typedef logic [3:0][3:0][11:0] board_t;
    localparam logic [15:0] SEED = 16'hACE1;

    logic   clk = 1'b0;
    logic   rst, start;
    board_t board_pre, board_in, board_out;
    logic   busy, done, spawned, win, game_over;

    tile_spawner #(.SEED(SEED), .WIN_VALUE(12'd2048)) dut (
        .clk(clk), .rst(rst), .start(start),
        .board_pre(board_pre), .board_in(board_in), .board_out(board_out),
        .busy(busy), .done(done), .spawned(spawned), .win(win), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic void model(input board_t pre, input board_t in, input logic [15:0] pl,
                                  output board_t b, output logic sp, output logic w,
                                  output logic go, output int lat);
        int empties, tgt, k;
        logic [11:0] v, tile;
        logic emp, pair;
        b = in;
        empties = 0;
        for (int i = 0; i < 16; i++) if (in[i/4][i%4] == 12'd0) empties++;
        sp  = (in != pre) && (empties > 0);
        lat = sp ? 50 : 34;
        tile = 12'd2;
`ifdef SPAWN_FOUR_EN
        if (pl[11:8] == 4'hF) tile = 12'd4;
`endif
        if (sp) begin
            tgt = (int'(pl[7:0]) * empties) / 256;
            k = 0;
            for (int i = 0; i < 16; i++) begin
                if (in[i/4][i%4] == 12'd0) begin
                    if (k == tgt) b[i/4][i%4] = tile;
                    k++;
                end
            end
        end
        w = 1'b0; emp = 1'b0; pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = b[r][c];
                if (v == 12'd0) emp = 1'b1;
                if (v >= 12'd2048) w = 1'b1;
                if (c < 3 && v == b[r][c+1]) pair = 1'b1;
                if (r < 3 && v == b[r+1][c]) pair = 1'b1;
            end
        end
        go = !emp && !pair;
    endfunction

    int          cyc = 0;
    logic [15:0] m_lfsr;
    logic        rst_edge = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
        m_lfsr   <= rst ? SEED : lfsr_step(m_lfsr);
    end

    // Expected operation (written by the driver) and expected held outputs (compare process)
    logic   m_active = 1'b0;
    int     m_a = 0, m_lat = 0;
    board_t p_board;
    logic   p_sp, p_win, p_go;
    board_t m_board = '0;
    logic   m_sp = 1'b0, m_win = 1'b0, m_go = 1'b0;
    int     last_done = -1;
    logic   chk_en = 1'b0;

    always @(negedge clk) begin
        logic e_done, e_busy;
        if (chk_en) begin
            if (rst_edge) begin
                m_board = '0; m_sp = 1'b0; m_win = 1'b0; m_go = 1'b0;
            end
            e_done = m_active && (cyc == m_a + m_lat);
            e_busy = m_active && (cyc >= m_a) && (cyc <= m_a + m_lat);
            if (e_done) begin
                m_board = p_board; m_sp = p_sp; m_win = p_win; m_go = p_go;
            end
            if (done) last_done = cyc;
            check("done", done, e_done);
            check("busy", busy, e_busy);
            check("board_out", board_out, m_board);
            check("spawned", spawned, m_sp);
            check("win", win, m_win);
            check("game_over", game_over, m_go);
        end
    end

    task automatic run_op(input board_t pre, input board_t in, input int lit_lat, input bit poke);
        logic [15:0] l;
        int lat;
        board_pre = pre; board_in = in; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = m_lfsr;
        repeat (16) l = lfsr_step(l);
        model(pre, in, l, p_board, p_sp, p_win, p_go, lat);
        m_a = cyc; m_lat = lat; m_active = 1'b1;
        check("model_latency", lat, lit_lat);
        while (cyc < m_a + m_lat + 1) begin
            if (poke && (cyc == m_a + 5 || cyc == m_a + m_lat)) begin
                start = 1'b1; board_in = ~in;
            end else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", last_done - m_a, lit_lat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_active = 1'b0;
    endtask

    board_t b_half, b_zero, b_chk, b_win, b_full, b_uniq;

    initial begin
        rst = 1'b1; start = 1'b0; board_pre = '0; board_in = '0;
        b_zero = '0;
        for (int i = 0; i < 16; i++) begin
            b_half[i/4][i%4] = (i < 8) ? 12'(4 << i) : 12'd0;
            b_chk[i/4][i%4]  = (((i/4) + (i%4)) % 2 == 1) ? 12'd4 : 12'd2;
            b_win[i/4][i%4]  = 12'd2;
            b_uniq[i/4][i%4] = 12'(i + 1);
        end
        b_full = b_chk;
        b_full[2][0] = 12'd8; b_full[2][1] = 12'd8; b_full[3][3] = 12'd2047;
        b_chk[1][3] = 12'd0;
        b_win[0][0] = 12'd2048; b_win[3][3] = 12'd0;
        b_uniq[1][1] = 12'd4095;

        check("lfsr_model_pin", lfsr_step(16'hACE1), 16'hE270);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(posedge clk); #1;

        run_op(b_half, b_half, 34, 1'b1);
        check("t2_spawned", spawned, 1'b0);
        check("t2_board", board_out, b_half);

        run_op(b_zero, b_half, 50, 1'b0);
        check("t2b_spawned", spawned, 1'b1);

        run_op(b_zero, b_chk, 50, 1'b1);
        check("t3_spawned", spawned, 1'b1);
`ifndef SPAWN_FOUR_EN
        check("t3_cell7", board_out[1][3], 12'd2);
        check("t3_game_over", game_over, 1'b1);
`endif

        run_op(b_zero, b_win, 50, 1'b0);
        check("t4_win", win, 1'b1);
        check("t4_game_over", game_over, 1'b0);

        run_op(b_zero, b_full, 34, 1'b0);
        check("t5_spawned", spawned, 1'b0);
        check("t5_game_over", game_over, 1'b0);
        check("t5_win_2047", win, 1'b0);

        // Abort mid-operation: reset lands on edge 20 after the accepting edge
        board_pre = b_zero; board_in = b_half; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_a = cyc; m_lat = 1000; m_active = 1'b1;
        while (cyc < m_a + 19) begin @(posedge clk); #1; end
        do_reset();
        check("abort_busy", busy, 1'b0);
        check("abort_board", board_out, b_zero);
        repeat (60) @(posedge clk); #1;

        run_op(b_half, b_zero, 50, 1'b0);
        check("t6_spawned", spawned, 1'b1);

        run_op(b_uniq, b_uniq, 34, 1'b0);
        check("t7_win", win, 1'b1);
        check("t7_game_over", game_over, 1'b1);

        repeat (3) @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
